// File: rtl/cola_solicitudes_if.sv
// Producer/consumer link between the request queue and the elevator FSM.
// The desborde flag only exists when COLA_DESBORDE_EN is defined.
interface cola_solicitudes_if #(
  parameter int AW = 3
);
  logic          LE;
  logic [3:0]    memoria;
  logic          vacia;
  logic          llena;
  logic [AW:0]   ocupacion;
`ifdef COLA_DESBORDE_EN
  logic          desborde;

  modport master (input LE, output memoria, vacia, llena, ocupacion, desborde);
  modport slave  (output LE, input memoria, vacia, llena, ocupacion, desborde);
`else
  modport master (input LE, output memoria, vacia, llena, ocupacion);
  modport slave  (output LE, input memoria, vacia, llena, ocupacion);
`endif
endinterface

// File: rtl/cola_solicitudes.sv
// Deduplicating FIFO of elevator button requests; head is shown on memoria.
// Define COLA_DESBORDE_EN to add the sticky desborde (dropped-on-full) flag.
module cola_solicitudes #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] boton_pres,
  input  logic [1:0] piso_m,
  input  logic [1:0] accion_m,
  input  logic       puertas_m,
  cola_solicitudes_if.master cola
);

  logic [3:0]    prev, ev_code, head, head_next, memoria;
  logic          ev_valid, vacia, llena, dup, do_pop, do_push;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count, count_next;
  logic [10:1]   pendiente, ev_sel, head_sel;
  logic [3:0]    mem [DEPTH];

  function automatic logic [1:0] floor_of(input logic [3:0] code);
    case (code)
      4'd1, 4'd5:       floor_of = 2'd0;
      4'd2, 4'd6, 4'd7: floor_of = 2'd1;
      4'd3, 4'd8, 4'd9: floor_of = 2'd2;
      default:          floor_of = 2'd3;
    endcase
  endfunction

  always_comb begin
    head = mem[rd_ptr];
    for (int i = 1; i <= 10; i++) begin
      ev_sel[i]   = (ev_code == 4'(i));
      head_sel[i] = (head == 4'(i));
    end
    dup     = |(pendiente & ev_sel);
    do_push = ev_valid && !dup && !llena;
    do_pop  = !vacia && (accion_m == 2'd0) && puertas_m && (floor_of(head) == piso_m);
    rd_next    = rd_ptr + {{(AW-1){1'b0}}, do_pop};
    count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    // A fresh write lands at the new head only when the queue was empty or just drained.
    head_next  = (do_push && (rd_next == wr_ptr)) ? ev_code : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ev_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= 4'd0;
      ev_code   <= 4'd0;
      ev_valid  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pendiente <= '0;
      memoria   <= 4'd0;
      vacia     <= 1'b1;
      llena     <= 1'b0;
    end else begin
      prev     <= boton_pres;
      ev_code  <= boton_pres;
      ev_valid <= (boton_pres != 4'd0) && (boton_pres <= 4'd10) && (boton_pres != prev);
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_next;
      count     <= count_next;
      pendiente <= (pendiente & ~(do_pop ? head_sel : 10'd0)) | (do_push ? ev_sel : 10'd0);
      vacia     <= (count_next == '0);
      llena     <= (count_next == (AW+1)'(DEPTH));
      if (cola.LE) memoria <= (count_next == '0) ? 4'd0 : head_next;
    end
  end

`ifdef COLA_DESBORDE_EN
  logic desborde;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) desborde <= 1'b0;
    else if (ev_valid && !dup && llena) desborde <= 1'b1;
  end

  assign cola.desborde = desborde;
`endif

  assign cola.memoria   = memoria;
  assign cola.vacia     = vacia;
  assign cola.llena     = llena;
  assign cola.ocupacion = count;

endmodule

// File: tb/tb_cola_solicitudes.sv
// Testbench for cola_solicitudes: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cola_solicitudes;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] boton = 4'd0;
  logic [1:0] piso = 2'd0;
  logic [1:0] accion = 2'd1;
  logic       puertas = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  cola_solicitudes_if #(.AW(AW)) cola();

  cola_solicitudes #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .boton_pres (boton),
    .piso_m     (piso),
    .accion_m   (accion),
    .puertas_m  (puertas),
    .cola       (cola)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests are simply the contents of a queue.
  int   q[$];
  int   m_prev = 0, m_ev_code = 0, m_mem = 0;
  bit   m_ev_valid = 0, m_desb = 0, m_pop, m_push;

  function automatic int floor_of(int c);
    if (c == 1 || c == 5) return 0;
    if (c == 2 || c == 6 || c == 7) return 1;
    if (c == 3 || c == 8 || c == 9) return 2;
    return 3;
  endfunction

  function automatic bit queued(int c);
    foreach (q[i]) if (q[i] == c) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_prev = 0; m_ev_code = 0; m_ev_valid = 0; m_mem = 0; m_desb = 0;
    end else begin
      m_pop  = (q.size() > 0) && (accion == 0) && puertas && (floor_of(q[0]) == piso);
      m_push = 0;
      if (m_ev_valid && !queued(m_ev_code)) begin
        if (q.size() == DEPTH) m_desb = 1;
        else m_push = 1;
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(m_ev_code);
      if (cola.LE) m_mem = (q.size() > 0) ? q[0] : 0;
      m_ev_valid = (boton >= 1) && (boton <= 10) && (int'(boton) != m_prev);
      m_ev_code  = boton;
      m_prev     = boton;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int code);
    boton = 4'(code);
    cycles(1);
    boton = 4'd0;
    cycles(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; boton = 4'd0; accion = 2'd1; puertas = 1'b0; cola.LE = 1'b1;
    cycles(1);
    rst = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    cola.LE = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (cola.vacia !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_vacia: got %0d expected 1", cola.vacia); end
    n_cmp++; if (cola.llena !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_llena: got %0d expected 0", cola.llena); end
    n_cmp++; if (cola.memoria !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_memoria: got %0d expected 0", cola.memoria); end
    @(negedge clk);
    rst = 1'b1;
    cycles(1);
    press(1); press(2); press(3);
    n_cmp++; if (cola.ocupacion !== 3) begin n_bad++; $display("[TB] FAIL pre_reset_ocupacion: got %0d expected 3", cola.ocupacion); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (cola.memoria !== 4'd0) begin n_bad++; $display("[TB] FAIL midrun_reset_memoria: got %0d expected 0", cola.memoria); end
    n_cmp++; if (cola.vacia !== 1'b1) begin n_bad++; $display("[TB] FAIL midrun_reset_vacia: got %0d expected 1", cola.vacia); end
    n_cmp++; if (cola.ocupacion !== 0) begin n_bad++; $display("[TB] FAIL midrun_reset_ocupacion: got %0d expected 0", cola.ocupacion); end
    @(negedge clk);
    rst = 1'b1;
    cycles(1);
  endtask

  task automatic test_dedup();
    do_reset();
    boton = 4'd7;
    cycles(5);
    boton = 4'd0;
    cycles(1);
    boton = 4'd7;
    cycles(1);
    boton = 4'd0;
    cycles(2);
    n_cmp++; if (cola.ocupacion !== 1) begin n_bad++; $display("[TB] FAIL dedup_ocupacion: got %0d expected 1", cola.ocupacion); end
    n_cmp++; if (cola.memoria !== 4'd7) begin n_bad++; $display("[TB] FAIL dedup_memoria: got %0d expected 7", cola.memoria); end
  endtask

  task automatic test_order();
    do_reset();
    press(3); press(5); press(10);
    piso = 2'd2; accion = 2'd0; puertas = 1'b1;
    cycles(2);
    n_cmp++; if (cola.memoria !== 4'd5) begin n_bad++; $display("[TB] FAIL order_memoria_5: got %0d expected 5", cola.memoria); end
    n_cmp++; if (cola.ocupacion !== 2) begin n_bad++; $display("[TB] FAIL order_ocupacion_2: got %0d expected 2", cola.ocupacion); end
    piso = 2'd0;
    cycles(2);
    n_cmp++; if (cola.memoria !== 4'd10) begin n_bad++; $display("[TB] FAIL order_memoria_10: got %0d expected 10", cola.memoria); end
    n_cmp++; if (cola.ocupacion !== 1) begin n_bad++; $display("[TB] FAIL order_ocupacion_1: got %0d expected 1", cola.ocupacion); end
    puertas = 1'b0; accion = 2'd1;
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 1; c <= 8; c++) press(c);
    n_cmp++; if (cola.llena !== 1'b1) begin n_bad++; $display("[TB] FAIL full_llena: got %0d expected 1", cola.llena); end
    press(9);
    cycles(1);
    n_cmp++; if (cola.ocupacion !== 8) begin n_bad++; $display("[TB] FAIL full_ocupacion: got %0d expected 8", cola.ocupacion); end
    n_cmp++; if (cola.memoria !== 4'd1) begin n_bad++; $display("[TB] FAIL full_memoria: got %0d expected 1", cola.memoria); end
    n_cmp++; if (q.size() != 8 || queued(9)) begin n_bad++; $display("[TB] FAIL full_model_drop: model size %0d, holds 9 = %0d", q.size(), queued(9)); end
`ifdef COLA_DESBORDE_EN
    n_cmp++; if (cola.desborde !== 1'b1) begin n_bad++; $display("[TB] FAIL full_desborde: got %0d expected 1", cola.desborde); end
`endif
  endtask

  task automatic test_le_freeze();
    do_reset();
    cola.LE = 1'b0;
    press(4);
    cycles(1);
    n_cmp++; if (cola.memoria !== 4'd0) begin n_bad++; $display("[TB] FAIL le_frozen_memoria: got %0d expected 0", cola.memoria); end
    n_cmp++; if (cola.ocupacion !== 1) begin n_bad++; $display("[TB] FAIL le_frozen_ocupacion: got %0d expected 1", cola.ocupacion); end
    cola.LE = 1'b1;
    cycles(1);
    n_cmp++; if (cola.memoria !== 4'd4) begin n_bad++; $display("[TB] FAIL le_release_memoria: got %0d expected 4", cola.memoria); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press(1); press(2); press(3);
    for (int i = 0; i < 22; i++) begin
      boton = 4'(((3 + i) % 10) + 1);
      piso = 2'(floor_of(q[0]));
      accion = 2'd0; puertas = 1'b1;
      cycles(1);
      n_cmp++; if (cola.memoria !== 4'(m_mem)) begin n_bad++; $display("[TB] FAIL wrap_memoria[%0d]: got %0d expected %0d", i, cola.memoria, m_mem); end
      n_cmp++; if (cola.ocupacion !== 2) begin n_bad++; $display("[TB] FAIL wrap_ocupacion[%0d]: got %0d expected 2", i, cola.ocupacion); end
    end
    boton = 4'd0; puertas = 1'b0; accion = 2'd1;
    cycles(2);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) boton = 4'($urandom_range(0, 15));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) piso = 2'(floor_of(q[0]));
      else piso = 2'($urandom_range(0, 3));
      accion  = 2'($urandom_range(0, 2));
      puertas = 1'($urandom_range(0, 1));
      cola.LE = ($urandom_range(0, 3) != 0);
      cycles(1);
      n_cmp++; if (cola.memoria !== 4'(m_mem)) begin n_bad++; $display("[TB] FAIL rand_memoria[%0d]: got %0d expected %0d", i, cola.memoria, m_mem); end
      n_cmp++; if (cola.ocupacion !== (AW+1)'(q.size())) begin n_bad++; $display("[TB] FAIL rand_ocupacion[%0d]: got %0d expected %0d", i, cola.ocupacion, q.size()); end
      n_cmp++; if (cola.vacia !== (q.size() == 0)) begin n_bad++; $display("[TB] FAIL rand_vacia[%0d]: got %0d expected %0d", i, cola.vacia, q.size() == 0); end
      n_cmp++; if (cola.llena !== (q.size() == DEPTH)) begin n_bad++; $display("[TB] FAIL rand_llena[%0d]: got %0d expected %0d", i, cola.llena, q.size() == DEPTH); end
`ifdef COLA_DESBORDE_EN
      n_cmp++; if (cola.desborde !== m_desb) begin n_bad++; $display("[TB] FAIL rand_desborde[%0d]: got %0d expected %0d", i, cola.desborde, m_desb); end
`endif
    end
    boton = 4'd0; puertas = 1'b0; accion = 2'd1; cola.LE = 1'b1;
  endtask

  initial begin
    test_reset();
    test_dedup();
    test_order();
    test_full();
    test_le_freeze();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
